// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared encodings for the ID/EX hazard and forwarding controller.
// Used by hazard_forward_ctrl (optional feature macro: HAZARD_FORWARDING_EN).
package hazard_forward_ctrl_pkg;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    localparam logic [3:0] PC_IDX = 4'd15;

    typedef enum logic {RUN, FLUSH} fsm_state_e;

    // The PC is never produced through the pipeline, so it never matches.
    function automatic logic src_match(input logic       valid,
                                       input logic       wb_en,
                                       input logic [3:0] src,
                                       input logic [3:0] dst);
        return valid & wb_en & (src == dst) & (src != PC_IDX);
    endfunction

    // EXE producer is younger than MEM producer, so it wins.
    function automatic logic [1:0] fwd_sel(input logic match_exe, input logic match_mem);
        if (match_exe) begin
            return SEL_MEM;
        end else if (match_mem) begin
            return SEL_WB;
        end
        return SEL_REG;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
module sat_counter #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);

    logic [COUNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + COUNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall, branch flush sequencing and EXE operand forwarding selects.
// HAZARD_FORWARDING_EN enables forwarding; otherwise hazards stall until resolved.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_W     = 16,
    parameter int unsigned FLUSH_EXTRA = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [3:0]         id_src1,
    input  logic [3:0]         id_src2,
    input  logic               id_two_src,
    input  logic [3:0]         exe_dst,
    input  logic               exe_wb_en,
    input  logic               exe_mem_read,
    input  logic               exe_b_taken,
    input  logic [3:0]         mem_dst,
    input  logic               mem_wb_en,
    output logic [1:0]         sel_src1,
    output logic [1:0]         sel_src2,
    output logic               stall,
    output logic               flush,
    output logic [COUNT_W-1:0] stall_cnt,
    output logic [COUNT_W-1:0] flush_cnt
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_EXTRA);

    fsm_state_e state_q;
    logic [3:0] left_q;
    logic       m1e, m1m, m2e, m2m;
    logic       hazard;

    always_comb begin
        m1e = src_match(id_valid, exe_wb_en, id_src1, exe_dst);
        m1m = src_match(id_valid, mem_wb_en, id_src1, mem_dst);
        m2e = id_two_src & src_match(id_valid, exe_wb_en, id_src2, exe_dst);
        m2m = id_two_src & src_match(id_valid, mem_wb_en, id_src2, mem_dst);
`ifdef HAZARD_FORWARDING_EN
        hazard = exe_mem_read & (m1e | m2e);
`else
        hazard = m1e | m1m | m2e | m2m;
`endif
    end

    // A hazard seen alongside a flush belongs to the wrong path.
    always_comb begin
        flush = ~rst & ((state_q == FLUSH) | exe_b_taken);
        stall = ~rst & ~flush & hazard;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            left_q  <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (exe_b_taken && (FLUSH_EXTRA > 0)) begin
                        state_q <= FLUSH;
                        left_q  <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (left_q <= 4'd1) begin
                        state_q <= RUN;
                        left_q  <= '0;
                    end else begin
                        left_q <= left_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    left_q  <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_FORWARDING_EN
    logic [1:0] sel1_d, sel2_d;
    logic [1:0] sel1_q, sel2_q;

    always_comb begin
        sel1_d = SEL_REG;
        sel2_d = SEL_REG;
        if (!(stall || flush)) begin
            sel1_d = fwd_sel(m1e, m1m);
            sel2_d = fwd_sel(m2e, m2m);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel1_q <= SEL_REG;
            sel2_q <= SEL_REG;
        end else begin
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
        end
    end

    assign sel_src1 = sel1_q;
    assign sel_src2 = sel2_q;
`else
    logic unused_mem_read;
    assign unused_mem_read = exe_mem_read;
    assign sel_src1        = SEL_REG;
    assign sel_src2        = SEL_REG;
`endif

    sat_counter #(
        .COUNT_W(COUNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall),
        .count(stall_cnt)
    );

    sat_counter #(
        .COUNT_W(COUNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (flush),
        .count(flush_cnt)
    );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl; the reference model follows HAZARD_FORWARDING_EN too.
module tb_hazard_forward_ctrl;

    localparam int CW     = 4;
    localparam int EXTRA  = 2;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0, id_two_src = 1'b0;
    logic [3:0]    id_src1 = '0, id_src2 = '0, exe_dst = '0, mem_dst = '0;
    logic          exe_wb_en = 1'b0, exe_mem_read = 1'b0, exe_b_taken = 1'b0, mem_wb_en = 1'b0;
    logic [1:0]    sel_src1, sel_src2;
    logic          stall, flush;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int vectors = 0;
    int errors  = 0;

    // Reference state: forwarding selects, remaining flush cycles, counter values.
    logic [1:0] m_sel1, m_sel2, n_sel1, n_sel2;
    int         m_left, m_scnt, m_fcnt;
    logic       exp_stall, exp_flush;

    hazard_forward_ctrl #(
        .COUNT_W    (CW),
        .FLUSH_EXTRA(EXTRA)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .exe_dst     (exe_dst),
        .exe_wb_en   (exe_wb_en),
        .exe_mem_read(exe_mem_read),
        .exe_b_taken (exe_b_taken),
        .mem_dst     (mem_dst),
        .mem_wb_en   (mem_wb_en),
        .sel_src1    (sel_src1),
        .sel_src2    (sel_src2),
        .stall       (stall),
        .flush       (flush),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit hit(input logic [3:0] s, input logic [3:0] d, input logic en);
        return id_valid && en && (s == d) && (s != 4'd15);
    endfunction

    task automatic model_reset();
        m_sel1 = 2'b00;
        m_sel2 = 2'b00;
        m_left = 0;
        m_scnt = 0;
        m_fcnt = 0;
    endtask

    task automatic model_eval();
        bit e1, w1, e2, w2;
        e1 = hit(id_src1, exe_dst, exe_wb_en);
        w1 = hit(id_src1, mem_dst, mem_wb_en);
        e2 = id_two_src && hit(id_src2, exe_dst, exe_wb_en);
        w2 = id_two_src && hit(id_src2, mem_dst, mem_wb_en);
        exp_flush = (m_left > 0) || exe_b_taken;
`ifdef HAZARD_FORWARDING_EN
        exp_stall = !exp_flush && exe_mem_read && (e1 || e2);
        n_sel1 = (exp_stall || exp_flush) ? 2'b00 : e1 ? 2'b01 : w1 ? 2'b10 : 2'b00;
        n_sel2 = (exp_stall || exp_flush) ? 2'b00 : e2 ? 2'b01 : w2 ? 2'b10 : 2'b00;
`else
        exp_stall = !exp_flush && (e1 || w1 || e2 || w2);
        n_sel1 = 2'b00;
        n_sel2 = 2'b00;
`endif
    endtask

    task automatic model_edge();
        m_sel1 = n_sel1;
        m_sel2 = n_sel2;
        if (exp_stall && m_scnt < CNTMAX) m_scnt++;
        if (exp_flush && m_fcnt < CNTMAX) m_fcnt++;
        if (m_left > 0) m_left--;
        else if (exe_b_taken) m_left = EXTRA;
    endtask

    task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                         input logic two, input logic [3:0] ed, input logic ewb,
                         input logic emr, input logic bt, input logic [3:0] md,
                         input logic mwb);
        id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
        exe_dst = ed; exe_wb_en = ewb; exe_mem_read = emr; exe_b_taken = bt;
        mem_dst = md; mem_wb_en = mwb;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        drive(1, 2, 0, 0, 2, 1, 1, 1, 0, 0);
        vectors++;
        if (stall !== 1'b0 || flush !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: stall=%b flush=%b required 0 0", stall, flush);
        end
        vectors++;
        if (sel_src1 !== 2'b00 || sel_src2 !== 2'b00 || stall_cnt !== '0 || flush_cnt !== '0) begin
            errors++;
            $display("FAIL reset_regs: sel=%b/%b cnt=%0d/%0d required 00/00 0/0",
                     sel_src1, sel_src2, stall_cnt, flush_cnt);
        end
        do_reset();
    endtask

    task automatic test_alu_fwd();
        do_reset();
        drive(1, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (stall !== exp_stall || flush !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall: stall=%b flush=%b required %b 0", stall, flush, exp_stall);
        end
        tick();
        vectors++;
        if (sel_src1 !== m_sel1 || sel_src2 !== 2'b00) begin
            errors++;
            $display("FAIL alu_sel: sel=%b/%b required %b/00", sel_src1, sel_src2, m_sel1);
        end
    endtask

    task automatic test_mem_fwd();
        do_reset();
        drive(1, 7, 3, 1, 9, 1, 0, 0, 3, 1);
        vectors++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL mem_stall: stall=%b required %b", stall, exp_stall);
        end
        tick();
        vectors++;
        if (sel_src2 !== m_sel2 || sel_src1 !== m_sel1) begin
            errors++;
            $display("FAIL mem_sel: sel=%b/%b required %b/%b", sel_src1, sel_src2, m_sel1, m_sel2);
        end
    endtask

    task automatic test_priority();
        do_reset();
        drive(1, 5, 0, 0, 5, 1, 0, 0, 5, 1);
        tick();
        vectors++;
        if (sel_src1 !== m_sel1) begin
            errors++;
            $display("FAIL prio_sel: sel_src1=%b required %b", sel_src1, m_sel1);
        end
        // PC source never matches even when a stage claims to write R15.
        drive(1, 15, 15, 1, 15, 1, 1, 0, 15, 1);
        vectors++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL pc_stall: stall=%b required 0", stall);
        end
        tick();
        vectors++;
        if (sel_src1 !== 2'b00 || sel_src2 !== 2'b00) begin
            errors++;
            $display("FAIL pc_sel: sel=%b/%b required 00/00", sel_src1, sel_src2);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 2, 0, 0, 2, 1, 1, 0, 0, 0);
        vectors++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall: stall=%b required 1", stall);
        end
        tick();
        vectors++;
        if (sel_src1 !== 2'b00 || stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lu_bubble: sel_src1=%b stall_cnt=%0d required 00 1", sel_src1, stall_cnt);
        end
        drive(1, 2, 0, 0, 8, 0, 0, 0, 2, 1);
        vectors++;
        if (stall !== exp_stall) begin
            errors++;
            $display("FAIL lu_stall2: stall=%b required %b", stall, exp_stall);
        end
        tick();
        vectors++;
        if (sel_src1 !== m_sel1 || stall_cnt !== 4'(m_scnt)) begin
            errors++;
            $display("FAIL lu_after: sel_src1=%b stall_cnt=%0d required %b %0d",
                     sel_src1, stall_cnt, m_sel1, m_scnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1, 2, 2, 1, 2, 1, 1, (c == 0), 2, 1);
            vectors++;
            if (flush !== 1'b1 || stall !== 1'b0) begin
                errors++;
                $display("FAIL br_cycle%0d: flush=%b stall=%b required 1 0", c, flush, stall);
            end
            tick();
            vectors++;
            if (sel_src1 !== 2'b00 || sel_src2 !== 2'b00) begin
                errors++;
                $display("FAIL br_sel%0d: sel=%b/%b required 00/00", c, sel_src1, sel_src2);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (flush !== 1'b0 || flush_cnt !== 4'd3 || stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL br_end: flush=%b flush_cnt=%0d stall_cnt=%0d required 0 3 0",
                     flush, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 4, 0, 0, 4, 1, 1, 0, 0, 0);
        vectors++;
        if (flush !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: flush=%b required 1", flush);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (flush !== 1'b0 || stall !== 1'b0 || flush_cnt !== '0) begin
            errors++;
            $display("FAIL mid_rst: flush=%b stall=%b flush_cnt=%0d required 0 0 0",
                     flush, stall, flush_cnt);
        end
        rst = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (flush !== 1'b0) begin
            errors++;
            $display("FAIL mid_run: flush=%b required 0 (FSM back in RUN)", flush);
        end
        tick();
    endtask

    function automatic logic [3:0] ridx();
        int unsigned r;
        r = $urandom_range(0, 9);
        return (r == 9) ? 4'd15 : 4'(r % 4);
    endfunction

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) != 0), ridx(), ridx(), 1'($urandom_range(0, 1)),
                  ridx(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), ridx(), 1'($urandom_range(0, 1)));
            vectors++;
            if (stall !== exp_stall || flush !== exp_flush) begin
                errors++;
                $display("FAIL rnd_comb%0d: stall=%b flush=%b required %b %b",
                         i, stall, flush, exp_stall, exp_flush);
            end
            tick();
            vectors++;
            if (sel_src1 !== m_sel1 || sel_src2 !== m_sel2 ||
                stall_cnt !== 4'(m_scnt) || flush_cnt !== 4'(m_fcnt)) begin
                errors++;
                $display("FAIL rnd_regs%0d: sel=%b/%b cnt=%0d/%0d required %b/%b %0d/%0d",
                         i, sel_src1, sel_src2, stall_cnt, flush_cnt,
                         m_sel1, m_sel2, m_scnt, m_fcnt);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_fwd();
        test_mem_fwd();
        test_priority();
        test_load_use();
        test_branch();
        test_reset_mid_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
